// File: rtl/s_stream_feeder_pkg.sv
// s_stream_feeder_pkg
//   Shared constants and types for the query-sequence feeder:
//   word geometry (PE_NUM bases per 128-bit word), storage depth,
//   o_s_valid encoding, base codes and the feeder state enum.
package s_stream_feeder_pkg;

   localparam int unsigned PE_NUM  = 64;
   localparam int unsigned PE_LOG  = 6;
   localparam int unsigned DEPTH   = 256;
   localparam int unsigned ADDR_W  = 8;
   localparam int unsigned WORD_W  = 2 * PE_NUM;
   localparam int unsigned TOTAL_W = 15;
   localparam int unsigned VALID_W = PE_LOG + 1;

   // o_s_valid code for a full, non-final word
   localparam logic [VALID_W-1:0] VALID_FULL = '1;

   localparam logic [TOTAL_W-1:0] WORD_BASES = TOTAL_W'(PE_NUM);
   localparam logic [TOTAL_W-1:0] S_MAX      = TOTAL_W'(PE_NUM * DEPTH);

   typedef enum logic [1:0] {
      BASE_A = 2'b00,
      BASE_C = 2'b01,
      BASE_G = 2'b10,
      BASE_T = 2'b11
   } base_e;

   typedef enum logic [1:0] {
      ST_EMPTY,
      ST_LOAD,
      ST_READY,
      ST_STREAM
   } state_e;

endpackage

// File: rtl/s_stream_feeder_if.sv
// s_stream_feeder_if
//   Bundles the host load channel and the core stream channel.
//   master: host/core side (drives i_* signals)
//   slave : feeder side (drives o_* signals)
//   i_load_valid/i_load_base/i_load_last, o_load_ready, o_s_total
//   i_busy, i_request_s, o_s, o_s_valid
interface s_stream_feeder_if;
   import s_stream_feeder_pkg::*;

   logic               i_load_valid;
   logic [1:0]         i_load_base;
   logic               i_load_last;
   logic               o_load_ready;
   logic [TOTAL_W-1:0] o_s_total;
   logic               i_busy;
   logic               i_request_s;
   logic [WORD_W-1:0]  o_s;
   logic [VALID_W-1:0] o_s_valid;

   modport master (
      output i_load_valid, i_load_base, i_load_last, i_busy, i_request_s,
      input  o_load_ready, o_s_total, o_s, o_s_valid
   );

   modport slave (
      input  i_load_valid, i_load_base, i_load_last, i_busy, i_request_s,
      output o_load_ready, o_s_total, o_s, o_s_valid
   );

endinterface

// File: rtl/s_word_ram.sv
// s_word_ram
//   DEPTH x WORD_W single-port synchronous RAM, one-cycle registered read.
//   clk     : clock
//   we_i    : write enable (wdata_i -> mem[addr_i])
//   re_i    : read enable  (mem[addr_i] -> rdata_o after the edge)
//   addr_i  : shared address
//   wdata_i : write data
//   rdata_o : registered read data (held between reads)
module s_word_ram
   import s_stream_feeder_pkg::*;
(
   input  logic              clk,
   input  logic              we_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [WORD_W-1:0] wdata_i,
   output logic [WORD_W-1:0] rdata_o
);

   logic [WORD_W-1:0] mem_q [DEPTH];
   logic [WORD_W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) mem_q[addr_i] <= wdata_i;
      if (re_i) rdata_q <= mem_q[addr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/s_stream_feeder.sv
// s_stream_feeder
//   Packs host bases (2 bits each, 64 per word) into s_word_ram and
//   replays them word by word to the Smith-Waterman core on request.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus_io     : s_stream_feeder_if.slave (load channel + stream channel)
//   Build option S_FEEDER_LOOP_EN: when defined, the final word wraps back
//   to word 0 so the sequence replays while busy; otherwise further
//   requests are ignored until i_busy falls.
module s_stream_feeder
   import s_stream_feeder_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   s_stream_feeder_if.slave bus_io
);

   state_e             state_q, state_d;
   logic [TOTAL_W-1:0] total_q, total_d;
   logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [TOTAL_W-1:0] remain_q, remain_d;
   logic [WORD_W-1:0]  pack_q, pack_d;
   logic [VALID_W-1:0] s_valid_q, s_valid_d;
   logic               done_q, done_d;
   logic               busy_q;

   logic               load_ready;
   logic               accept;
   logic               start;
   logic [TOTAL_W-1:0] cur_total;
   logic [TOTAL_W-1:0] new_total;
   logic [ADDR_W-1:0]  cur_wr;
   logic [PE_LOG-1:0]  idx;
   logic [WORD_W-1:0]  pack_word;
   logic               last_eff;

   logic               ram_we;
   logic               ram_re;
   logic [ADDR_W-1:0]  ram_addr;
   logic [WORD_W-1:0]  ram_rdata;

   always_comb begin
      state_d   = state_q;
      total_d   = total_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      remain_d  = remain_q;
      pack_d    = pack_q;
      done_d    = done_q;
      s_valid_d = '0;
      ram_we    = 1'b0;
      ram_re    = 1'b0;
      ram_addr  = wr_ptr_q;

      load_ready = (state_q != ST_STREAM);
      accept     = bus_io.i_load_valid && load_ready;

      // A beat in EMPTY/READY begins a fresh sequence at base 0, word 0.
      start     = (state_q == ST_EMPTY) || (state_q == ST_READY);
      cur_total = start ? '0 : total_q;
      cur_wr    = start ? '0 : wr_ptr_q;
      idx       = cur_total[PE_LOG-1:0];
      new_total = cur_total + 1'b1;
      last_eff  = bus_io.i_load_last || (new_total == S_MAX);

      // Clearing at word start keeps a flushed partial word zero above its bases.
      pack_word = (idx == '0) ? '0 : pack_q;
      pack_word[{idx, 1'b0} +: 2] = bus_io.i_load_base;

      case (state_q)
         ST_EMPTY, ST_LOAD, ST_READY: begin
            if (accept) begin
               total_d  = new_total;
               wr_ptr_d = cur_wr;
               pack_d   = pack_word;
               if ((&idx) || last_eff) begin
                  ram_we   = 1'b1;
                  ram_addr = cur_wr;
                  pack_d   = '0;
                  if (&idx) wr_ptr_d = cur_wr + 1'b1;
               end
               state_d = last_eff ? ST_READY : ST_LOAD;
            end else if (state_q == ST_READY && bus_io.i_busy && !busy_q) begin
               state_d  = ST_STREAM;
               rd_ptr_d = '0;
               remain_d = total_q;
               done_d   = 1'b0;
            end
         end
         ST_STREAM: begin
            if (!bus_io.i_busy) begin
               state_d  = ST_READY;
               rd_ptr_d = '0;
               remain_d = total_q;
               done_d   = 1'b0;
            end else if (bus_io.i_request_s && (s_valid_q == '0) && !done_q &&
                         (total_q != '0)) begin
               ram_re   = 1'b1;
               ram_addr = rd_ptr_q;
               if (remain_q <= WORD_BASES) begin
                  s_valid_d = remain_q[VALID_W-1:0];
`ifdef S_FEEDER_LOOP_EN
                  rd_ptr_d  = '0;
                  remain_d  = total_q;
`else
                  done_d    = 1'b1;
`endif
               end else begin
                  s_valid_d = VALID_FULL;
                  rd_ptr_d  = rd_ptr_q + 1'b1;
                  remain_d  = remain_q - WORD_BASES;
               end
            end
         end
         default: state_d = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_EMPTY;
         total_q   <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         remain_q  <= '0;
         pack_q    <= '0;
         s_valid_q <= '0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         total_q   <= total_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         remain_q  <= remain_d;
         pack_q    <= pack_d;
         s_valid_q <= s_valid_d;
         done_q    <= done_d;
         busy_q    <= bus_io.i_busy;
      end
   end

   s_word_ram u_ram (
      .clk     (clk),
      .we_i    (ram_we),
      .re_i    (ram_re),
      .addr_i  (ram_addr),
      .wdata_i (pack_word),
      .rdata_o (ram_rdata)
   );

   assign bus_io.o_load_ready = load_ready;
   assign bus_io.o_s_total    = total_q;
   assign bus_io.o_s_valid    = s_valid_q;
   assign bus_io.o_s          = ram_rdata & {WORD_W{s_valid_q != '0}};

endmodule

// File: tb/tb_s_stream_feeder.sv
module tb_s_stream_feeder;
   import s_stream_feeder_pkg::*;

   typedef struct {
      logic [6:0]   v;
      logic [127:0] w;
   } exp_t;

`ifdef S_FEEDER_LOOP_EN
   localparam logic [6:0] WRAP_V  = 7'd127;
   localparam logic [6:0] WRAP_64 = 7'd64;
`else
   localparam logic [6:0] WRAP_V  = 7'd0;
   localparam logic [6:0] WRAP_64 = 7'd0;
`endif

   logic clk;
   logic rst_n;
   s_stream_feeder_if bus ();

   s_stream_feeder dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus_io (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   exp_t sb[$];

   // bench model of the feeder
   logic [1:0] sm [0:16383];
   int   m_total  = 0;
   int   m_rd     = 0;
   int   m_remain = 0;
   bit   m_done   = 0;
   bit   m_ready  = 0;
   bit   m_stream = 0;
   logic [6:0] m_last_v = '0;

   task automatic model_serve(output exp_t e);
      int cnt;
      e.v = '0;
      e.w = '0;
      if (m_stream && !m_done && m_total != 0 && m_last_v == 0) begin
         cnt = (m_remain <= 64) ? m_remain : 64;
         for (int k = 0; k < 64; k++)
            if (k < cnt) e.w[2*k +: 2] = sm[m_rd*64 + k];
         if (m_remain <= 64) begin
            e.v = 7'(m_remain);
`ifdef S_FEEDER_LOOP_EN
            m_rd     = 0;
            m_remain = m_total;
`else
            m_done   = 1;
`endif
         end else begin
            e.v      = 7'd127;
            m_rd     = m_rd + 1;
            m_remain = m_remain - 64;
         end
      end
      m_last_v = e.v;
   endtask

   task automatic load_seq(input int n, input bit mark_last, input bit chk);
      logic [1:0] b;
      m_stream = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         b = 2'($urandom);
         sm[i] = b;
         bus.i_load_valid = 1'b1;
         bus.i_load_base  = b;
         bus.i_load_last  = mark_last && (i == n - 1);
         @(posedge clk); #1;
         if (chk) begin
            n_cmp++;
            if (bus.o_s_total !== 15'(i + 1)) begin
               n_fail++;
               $display("FAIL load_total[%0d]: got %0d want %0d", i, bus.o_s_total, i + 1);
            end
         end
      end
      @(negedge clk);
      bus.i_load_valid = 1'b0;
      bus.i_load_last  = 1'b0;
      m_total = n;
      m_ready = mark_last || (n == 16384);
   endtask

   task automatic set_busy(input logic b);
      @(negedge clk);
      bus.i_busy = b;
      if (b && m_ready && !m_stream) begin
         m_stream = 1;
         m_rd     = 0;
         m_remain = m_total;
         m_done   = 0;
      end else if (!b) begin
         m_stream = 0;
      end
      @(negedge clk);
   endtask

   task automatic issue_req(output exp_t obs, output logic [6:0] after_v);
      exp_t e;
      @(negedge clk);
      bus.i_request_s = 1'b1;
      m_last_v = '0;
      model_serve(e);
      sb.push_back(e);
      @(posedge clk); #1;
      obs.v = bus.o_s_valid;
      obs.w = bus.o_s;
      @(negedge clk);
      bus.i_request_s = 1'b0;
      @(posedge clk); #1;
      after_v = bus.o_s_valid;
   endtask

   task automatic test_reset();
      n_cmp++;
      if (bus.o_s_total !== '0) begin
         n_fail++; $display("FAIL reset_total: got %0d want 0", bus.o_s_total);
      end
      n_cmp++;
      if (bus.o_s_valid !== '0) begin
         n_fail++; $display("FAIL reset_valid: got %0d want 0", bus.o_s_valid);
      end
      n_cmp++;
      if (bus.o_s !== '0) begin
         n_fail++; $display("FAIL reset_s: got %h want 0", bus.o_s);
      end
      n_cmp++;
      if (bus.o_load_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_ready: got %b want 1", bus.o_load_ready);
      end
   endtask

   task automatic test_load130();
      exp_t o, e;
      logic [6:0] av;
      logic [6:0] tab [4];
      tab[0] = 7'd127; tab[1] = 7'd127; tab[2] = 7'd2; tab[3] = WRAP_V;
      load_seq(130, 1'b1, 1'b1);
      set_busy(1'b1);
      n_cmp++;
      if (bus.o_load_ready !== 1'b0) begin
         n_fail++; $display("FAIL stream_ready: got %b want 0", bus.o_load_ready);
      end
      for (int r = 0; r < 4; r++) begin
         issue_req(o, av);
         e = sb.pop_front();
         n_cmp++;
         if (o.v !== e.v || o.v !== tab[r]) begin
            n_fail++; $display("FAIL l130_valid[%0d]: got %0d want %0d", r, o.v, tab[r]);
         end
         n_cmp++;
         if (o.w !== e.w) begin
            n_fail++; $display("FAIL l130_word[%0d]: got %h want %h", r, o.w, e.w);
         end
         n_cmp++;
         if (av !== '0) begin
            n_fail++; $display("FAIL l130_oneshot[%0d]: got %0d want 0", r, av);
         end
         if (r == 2) begin
            n_cmp++;
            if (o.w[127:4] !== '0) begin
               n_fail++; $display("FAIL l130_tail_zero: got %h want 0", o.w[127:4]);
            end
         end
      end
      set_busy(1'b0);
   endtask

   task automatic test_word64();
      exp_t o, e;
      logic [6:0] av;
      load_seq(64, 1'b1, 1'b0);
      n_cmp++;
      if (bus.o_s_total !== 15'd64) begin
         n_fail++; $display("FAIL w64_total: got %0d want 64", bus.o_s_total);
      end
      set_busy(1'b1);
      for (int r = 0; r < 2; r++) begin
         issue_req(o, av);
         e = sb.pop_front();
         n_cmp++;
         if (o.v !== e.v || o.v !== ((r == 0) ? 7'd64 : WRAP_64)) begin
            n_fail++; $display("FAIL w64_valid[%0d]: got %0d want %0d", r, o.v, e.v);
         end
         n_cmp++;
         if (o.w !== e.w) begin
            n_fail++; $display("FAIL w64_word[%0d]: got %h want %h", r, o.w, e.w);
         end
      end
      set_busy(1'b0);
   endtask

   task automatic test_back_to_back();
      exp_t o, e;
      int n_resp = 0;
      logic [6:0] prev = '0;
      load_seq(150, 1'b1, 1'b0);
      set_busy(1'b1);
      m_last_v = '0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         bus.i_request_s = 1'b1;
         model_serve(e);
         sb.push_back(e);
         @(posedge clk); #1;
         o.v = bus.o_s_valid;
         o.w = bus.o_s;
         e = sb.pop_front();
         n_cmp++;
         if (o.v !== e.v) begin
            n_fail++; $display("FAIL b2b_valid[%0d]: got %0d want %0d", c, o.v, e.v);
         end
         n_cmp++;
         if (o.w !== e.w) begin
            n_fail++; $display("FAIL b2b_word[%0d]: got %h want %h", c, o.w, e.w);
         end
         if (o.v != 0 && prev != 0) begin
            n_fail++; $display("FAIL b2b_consecutive[%0d]: got %0d after %0d want gap", c, o.v, prev);
         end
         if (o.v != 0) n_resp++;
         prev = o.v;
      end
      @(negedge clk);
      bus.i_request_s = 1'b0;
      n_cmp++;
      if (n_resp != 3) begin
         n_fail++; $display("FAIL b2b_count: got %0d want 3", n_resp);
      end
      set_busy(1'b0);
   endtask

   task automatic test_busy_drop();
      exp_t o, e;
      logic [6:0] av;
      for (int r = 0; r < 2; r++) begin
         set_busy(1'b1);
         issue_req(o, av);
         e = sb.pop_front();
         n_cmp++;
         if (o.v !== e.v || o.v !== 7'd127) begin
            n_fail++; $display("FAIL drop_valid[%0d]: got %0d want 127", r, o.v);
         end
         n_cmp++;
         if (o.w !== e.w) begin
            n_fail++; $display("FAIL drop_word[%0d]: got %h want %h", r, o.w, e.w);
         end
         set_busy(1'b0);
      end
   endtask

   task automatic test_full();
      exp_t o, e;
      logic [6:0] av;
      load_seq(16384, 1'b0, 1'b0);
      n_cmp++;
      if (bus.o_s_total !== 15'd16384) begin
         n_fail++; $display("FAIL full_total: got %0d want 16384", bus.o_s_total);
      end
      set_busy(1'b1);
      for (int r = 0; r < 257; r++) begin
         issue_req(o, av);
         e = sb.pop_front();
         n_cmp++;
         if (o.v !== e.v) begin
            n_fail++; $display("FAIL full_valid[%0d]: got %0d want %0d", r, o.v, e.v);
         end
         n_cmp++;
         if (o.w !== e.w) begin
            n_fail++; $display("FAIL full_word[%0d]: got %h want %h", r, o.w, e.w);
         end
         if (r == 255) begin
            n_cmp++;
            if (o.v !== 7'd64) begin
               n_fail++; $display("FAIL full_last: got %0d want 64", o.v);
            end
         end
      end
      set_busy(1'b0);
   endtask

   task automatic test_reset_midload();
      exp_t o, e;
      logic [6:0] av;
      load_seq(50, 1'b0, 1'b0);
      @(negedge clk);
      #2 rst_n = 1'b0;
      m_total = 0; m_ready = 0; m_stream = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_cmp++;
      if (bus.o_s_total !== '0) begin
         n_fail++; $display("FAIL rst_total: got %0d want 0", bus.o_s_total);
      end
      n_cmp++;
      if (bus.o_load_ready !== 1'b1) begin
         n_fail++; $display("FAIL rst_ready: got %b want 1", bus.o_load_ready);
      end
      set_busy(1'b1);
      for (int r = 0; r < 3; r++) begin
         issue_req(o, av);
         e = sb.pop_front();
         n_cmp++;
         if (o.v !== e.v || o.v !== 7'd0) begin
            n_fail++; $display("FAIL rst_req[%0d]: got %0d want 0", r, o.v);
         end
      end
      set_busy(1'b0);
   endtask

   initial begin
      rst_n            = 1'b0;
      bus.i_load_valid = 1'b0;
      bus.i_load_base  = 2'b00;
      bus.i_load_last  = 1'b0;
      bus.i_busy       = 1'b0;
      bus.i_request_s  = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      test_reset();
      rst_n = 1'b1;
      test_load130();
      test_word64();
      test_back_to_back();
      test_busy_drop();
      test_full();
      test_reset_midload();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
